soc_timer: RTL and testbench
============================

# soc_timer

Memory-mapped 32-bit timer/compare peripheral that acts as a responder on the PicoRV32 native memory bus (`mem_valid`/`mem_ready`/`mem_addr`/`mem_wdata`/`mem_wstrb`/`mem_rdata`). It sits in the SoC I/O region beside the LED register and UART and answers CPU loads and stores with a fixed one-cycle latency. A prescaled free-running counter sets a sticky match flag against a compare register. That flag drives a level interrupt output.

## Interface
- `BASE_ADDR`, 32'h0300_0000: base of the 32-byte register window; hit when `mem_addr[31:5] == BASE_ADDR[31:5]`.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_valid`  in  1  CPU request valid.
- `mem_addr`  in  32  byte address; `[4:2]` selects the register, `[1:0]` ignored.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte write enables; 4'b0000 = read.
- `mem_ready`  out  1  one-cycle acknowledge pulse.
- `mem_rdata`  out  32  read data; valid only while `mem_ready`=1, else 32'h0, so the top level can OR it into the shared bus mux.
- `irq`  out  1  level interrupt = `STATUS.MATCH & CTRL.IRQ_EN`.

## Operation
- Register map, as offset from `BASE_ADDR`:
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x04 COUNT: 32-bit read/write current count.
  - 0x08 COMPARE: 32-bit read/write.
  - 0x0C STATUS: bit0 MATCH, sticky; writing 1 with `wstrb[0]` clears it, writing 0 has no effect.
  - 0x10 PRESCALE: bits[15:0] read/write; bits[31:16] read 0.
  - 0x14–0x1C: reserved; reads return 0, writes are ignored, and the access is still acknowledged.
- Writes are byte-granular per `mem_wstrb` on every read/write register.
- Prescaler: internal 16-bit `pre_cnt`.
  - While EN=1: `pre_cnt == PRESCALE` produces `tick` and sets `pre_cnt` to 0; otherwise `pre_cnt` increments.
  - While EN=0: `pre_cnt` and COUNT hold.
- On `tick`:
  - If COUNT == COMPARE: set MATCH. COUNT goes to 0 when AUTO_RELOAD=1, otherwise COUNT+1.
  - If COUNT != COMPARE: COUNT+1, wrapping mod 2^32 (0xFFFF_FFFF → 0).
- Simultaneous events:
  - A bus write to COUNT in the same cycle as `tick` takes priority: the written bytes land, the unwritten bytes keep their old value, and no increment happens that cycle.
  - A match set and a software MATCH clear in the same cycle leave MATCH = 1.
  - Any write to PRESCALE clears `pre_cnt` to 0.
- Bus handshake: `hit = mem_valid && address in window`.
  - `mem_ready` <= `hit && !mem_ready`. This guarantees a single-cycle pulse even if `mem_valid` stays high through the ack cycle.
  - Writes commit on the same edge that raises `mem_ready`.
  - Read data is sampled on that edge from register state before any same-edge update.
- Non-hit requests are ignored completely: no ready, `rdata` = 0.

## Timing
- Reset values: CTRL, COUNT, COMPARE, STATUS, PRESCALE and `pre_cnt` = 0; `mem_ready` = 0, `mem_rdata` = 0, `irq` = 0.
- Reset asserted mid-transaction abandons the access: `mem_ready` is 0 the next cycle and the write is not committed.
- Access latency: `mem_valid` rising at edge N gives `mem_ready`=1 in cycle N+1, then 0 in cycle N+2 regardless of `mem_valid`.
- Back-to-back accesses take a minimum of 2 cycles each.
- Tick rate: one COUNT step per PRESCALE+1 enabled cycles. PRESCALE=0 steps COUNT every cycle.
- First tick after EN goes 0→1 (with `pre_cnt`=0) occurs PRESCALE+1 cycles after the CTRL write edge.
- MATCH rises on the edge of the matching tick; `irq` follows combinationally from registered MATCH and IRQ_EN, so there is no extra cycle.

## Test plan
- Reset, then read all five registers and offset 0x18 → each returns 0. Each `mem_ready` pulse is exactly 1 cycle wide, with `mem_valid` held high for 2 cycles.
- COMPARE=5, PRESCALE=0, CTRL=0x7 → MATCH and `irq` rise on the 6th enabled cycle and COUNT reads 0 afterward. Writing STATUS=1 → `irq` drops the next cycle; the next match follows 6 cycles later.
- PRESCALE=3, CTRL=0x1, COMPARE=0xFFFF_FFFF → COUNT increments every 4 cycles. COUNT preloaded to 0xFFFF_FFFE reaches 0xFFFF_FFFF, then 0; MATCH is set on the 0xFFFF_FFFF tick.
- Write COUNT=0x1234_5678 with `wstrb`=4'b0011 over a value of 0xAAAA_AAAA on a tick cycle → reads 0xAAAA_5678 with no increment that cycle.
- Issue a MATCH clear on the same cycle a match occurs → MATCH stays 1.
- Assert `reset` during a pending COMPARE write → no ack, and COMPARE stays 0. A request at a non-window address (0x0200_0000) → no `mem_ready` and `rdata`=0.

Source files
------------

// File: rtl/soc_timer_if.sv
// PicoRV32 native memory bus bundle between the CPU (master)
// and a memory-mapped responder (slave).
interface soc_timer_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/soc_timer.sv
// Timer/compare peripheral on the PicoRV32 bus: prescaled counter,
// sticky compare match and level interrupt, one-cycle bus ack.
module soc_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        reset,
    soc_timer_if.slave  bus,
    output logic        irq
);
    localparam logic [2:0] A_CTRL  = 3'd0;
    localparam logic [2:0] A_COUNT = 3'd1;
    localparam logic [2:0] A_CMP   = 3'd2;
    localparam logic [2:0] A_STAT  = 3'd3;
    localparam logic [2:0] A_PRE   = 3'd4;

    logic [2:0]  r_ctrl;
    logic [31:0] r_count;
    logic [31:0] r_cmp;
    logic        r_match;
    logic [15:0] r_pre;
    logic [15:0] r_pre_cnt;
    logic        r_ready;
    logic [31:0] r_rdata;

    logic        w_hit;
    logic        w_acc;
    logic        w_wr;
    logic        w_tick;
    logic        w_eq;
    logic [2:0]  w_sel;
    logic [31:0] w_rd;
    logic [31:0] w_pre_m;
    logic        w_unused;

    function automatic logic [31:0] f_merge(
        input logic [31:0] i_old,
        input logic [31:0] i_new,
        input logic [3:0]  i_be
    );
        logic [31:0] v;
        for (int i = 0; i < 4; i++)
            v[8*i +: 8] = i_be[i] ? i_new[8*i +: 8] : i_old[8*i +: 8];
        return v;
    endfunction

    assign w_unused = ^bus.mem_addr[1:0];
    assign w_hit    = bus.mem_valid &&
                      (bus.mem_addr[31:5] == BASE_ADDR[31:5]);
    // Suppressing the ack cycle keeps mem_ready a single-cycle pulse.
    assign w_acc    = w_hit && !r_ready;
    assign w_wr     = w_acc && (bus.mem_wstrb != 4'b0000);
    assign w_sel    = bus.mem_addr[4:2];
    assign w_tick   = r_ctrl[0] && (r_pre_cnt == r_pre);
    assign w_eq     = (r_count == r_cmp);
    assign w_pre_m  = f_merge({16'h0, r_pre}, bus.mem_wdata,
                              bus.mem_wstrb);

    always_comb begin
        w_rd = 32'h0;
        unique case (w_sel)
            A_CTRL:  w_rd = {29'h0, r_ctrl};
            A_COUNT: w_rd = r_count;
            A_CMP:   w_rd = r_cmp;
            A_STAT:  w_rd = {31'h0, r_match};
            A_PRE:   w_rd = {16'h0, r_pre};
            default: w_rd = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl    <= 3'h0;
            r_count   <= 32'h0;
            r_cmp     <= 32'h0;
            r_match   <= 1'b0;
            r_pre     <= 16'h0;
            r_pre_cnt <= 16'h0;
            r_ready   <= 1'b0;
            r_rdata   <= 32'h0;
        end else begin
            r_ready <= w_acc;
            r_rdata <= w_acc ? w_rd : 32'h0;

            if (w_wr && w_sel == A_CTRL && bus.mem_wstrb[0])
                r_ctrl <= bus.mem_wdata[2:0];

            if (w_wr && w_sel == A_CMP)
                r_cmp <= f_merge(r_cmp, bus.mem_wdata, bus.mem_wstrb);

            if (w_wr && w_sel == A_PRE) begin
                r_pre     <= w_pre_m[15:0];
                r_pre_cnt <= 16'h0;
            end else if (r_ctrl[0]) begin
                r_pre_cnt <= w_tick ? 16'h0 : r_pre_cnt + 16'd1;
            end

            // A software write to COUNT overrides that cycle's tick.
            if (w_wr && w_sel == A_COUNT)
                r_count <= f_merge(r_count, bus.mem_wdata, bus.mem_wstrb);
            else if (w_tick)
                r_count <= (w_eq && r_ctrl[1]) ? 32'h0 : r_count + 32'd1;

            if (w_tick && w_eq)
                r_match <= 1'b1;
            else if (w_wr && w_sel == A_STAT &&
                     bus.mem_wstrb[0] && bus.mem_wdata[0])
                r_match <= 1'b0;
        end
    end

    assign bus.mem_ready = r_ready;
    assign bus.mem_rdata = r_rdata;
    assign irq           = r_match & r_ctrl[2];
endmodule

// File: tb/tb_soc_timer.sv
// Self-checking bench for soc_timer: bus protocol, register map,
// randomized counter/match scenarios against a tick-level model.
module tb_soc_timer;
    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam logic [31:0] O_CTRL = BASE + 32'h00;
    localparam logic [31:0] O_CNT  = BASE + 32'h04;
    localparam logic [31:0] O_CMP  = BASE + 32'h08;
    localparam logic [31:0] O_STAT = BASE + 32'h0C;
    localparam logic [31:0] O_PRE  = BASE + 32'h10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic irq;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;

    logic [31:0] g_rd;
    logic [31:0] g_dummy;
    bit          g_ok;
    int          g_edge;

    soc_timer_if bus ();

    soc_timer #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Holds mem_valid for two cycles; ok means a one-cycle ready pulse.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd,
                        output bit ok);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_wstrb = s;
        @(posedge clk); #1;
        g_edge = cyc;
        ok = (bus.mem_ready === 1'b1);
        rd = bus.mem_rdata;
        @(posedge clk); #1;
        ok = ok && (bus.mem_ready === 1'b0) && (bus.mem_rdata === 32'h0);
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        xfer(a, d, s, g_dummy, g_ok);
    endtask

    task automatic rd(input logic [31:0] a);
        xfer(a, 32'h0, 4'h0, g_rd, g_ok);
    endtask

    // Applies n counter ticks using the register-level rules.
    function automatic void model(input logic [31:0] start,
                                  input logic [31:0] cmp,
                                  input bit auto_rl, input int n,
                                  output logic [31:0] cnt,
                                  output bit m);
        cnt = start;
        m = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (cnt == cmp) begin
                m = 1'b1;
                cnt = auto_rl ? 32'h0 : cnt + 32'd1;
            end else begin
                cnt = cnt + 32'd1;
            end
        end
    endfunction

    task automatic test_reset;
        logic [31:0] addrs [6];
        addrs = '{O_CTRL, O_CNT, O_CMP, O_STAT, O_PRE, BASE + 32'h18};
        nchk++;
        if (bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'h0 ||
            irq !== 1'b0) begin
            nerr++;
            $display("FAIL reset_outputs ready=%b rdata=%h irq=%b want 0",
                     bus.mem_ready, bus.mem_rdata, irq);
        end
        foreach (addrs[i]) begin
            rd(addrs[i]);
            nchk++;
            if (g_rd !== 32'h0 || !g_ok) begin
                nerr++;
                $display("FAIL reset_read a=%h got=%h ok=%b want 0 ok=1",
                         addrs[i], g_rd, g_ok);
            end
        end
    endtask

    task automatic test_regs;
        wr(O_PRE, 32'hFFFF_FFFF, 4'hF);
        rd(O_PRE);
        nchk++;
        if (g_rd !== 32'h0000_FFFF) begin
            nerr++;
            $display("FAIL prescale_rw got=%h want 0000ffff", g_rd);
        end
        wr(O_CTRL, 32'hFFFF_FFFF, 4'hF);
        rd(O_CTRL);
        nchk++;
        if (g_rd !== 32'h7) begin
            nerr++;
            $display("FAIL ctrl_rw got=%h want 00000007", g_rd);
        end
        wr(O_CTRL, 32'h0, 4'hF);
        wr(O_PRE, 32'h0, 4'hF);
        wr(O_CMP, 32'h1122_3344, 4'hF);
        wr(O_CMP, 32'hAABB_CCDD, 4'b0101);
        rd(O_CMP);
        nchk++;
        if (g_rd !== 32'h11BB_33DD) begin
            nerr++;
            $display("FAIL cmp_bytes got=%h want 11bb33dd", g_rd);
        end
        wr(BASE + 32'h1C, 32'h5A5A_5A5A, 4'hF);
        nchk++;
        if (!g_ok) begin
            nerr++;
            $display("FAIL reserved_ack got=0 want=1");
        end
        rd(BASE + 32'h1C);
        nchk++;
        if (g_rd !== 32'h0) begin
            nerr++;
            $display("FAIL reserved_read got=%h want 0", g_rd);
        end
    endtask

    task automatic test_match_autoreload;
        int e;
        logic [31:0] c;
        bit m;
        bit exp_irq;
        wr(O_STAT, 32'h1, 4'hF);
        wr(O_PRE, 32'h0, 4'hF);
        wr(O_CNT, 32'h0, 4'hF);
        wr(O_CMP, 32'd5, 4'hF);
        wr(O_CTRL, 32'h7, 4'hF);
        e = g_edge;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            exp_irq = (cyc - e >= 6);
            nchk++;
            if (irq !== exp_irq) begin
                nerr++;
                $display("FAIL match_irq_edge k=%0d got=%b want=%b",
                         cyc - e, irq, exp_irq);
            end
        end
        rd(O_CNT);
        model(32'h0, 32'd5, 1'b1, g_edge - 1 - e, c, m);
        nchk++;
        if (g_rd !== c) begin
            nerr++;
            $display("FAIL autoreload_count got=%h want=%h", g_rd, c);
        end
        wr(O_STAT, 32'h1, 4'h1);
        nchk++;
        if (irq !== 1'b0) begin
            nerr++;
            $display("FAIL irq_clear got=%b want=0", irq);
        end
        while (cyc < e + 12) begin
            @(posedge clk); #1;
        end
        nchk++;
        if (irq !== 1'b1) begin
            nerr++;
            $display("FAIL second_match got=%b want=1", irq);
        end
        wr(O_CTRL, 32'h0, 4'hF);
    endtask

    task automatic test_wrap;
        int e;
        logic [31:0] c;
        bit m;
        wr(O_CTRL, 32'h0, 4'hF);
        wr(O_STAT, 32'h1, 4'hF);
        wr(O_PRE, 32'd3, 4'hF);
        wr(O_CMP, 32'hFFFF_FFFF, 4'hF);
        wr(O_CNT, 32'hFFFF_FFFE, 4'hF);
        wr(O_CTRL, 32'h1, 4'hF);
        e = g_edge;
        for (int i = 0; i < 6; i++) begin
            rd(O_CNT);
            model(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0,
                  (g_edge - 1 - e) / 4, c, m);
            nchk++;
            if (g_rd !== c) begin
                nerr++;
                $display("FAIL wrap_count i=%0d got=%h want=%h", i, g_rd, c);
            end
        end
        rd(O_STAT);
        model(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0,
              (g_edge - 1 - e) / 4, c, m);
        nchk++;
        if (g_rd !== {31'h0, m} || irq !== 1'b0) begin
            nerr++;
            $display("FAIL wrap_match got=%h irq=%b want=%0d irq=0",
                     g_rd, irq, m);
        end
        wr(O_CTRL, 32'h0, 4'hF);
    endtask

    task automatic test_count_write_on_tick;
        int w;
        logic [31:0] c;
        bit m;
        wr(O_CTRL, 32'h0, 4'hF);
        wr(O_PRE, 32'h0, 4'hF);
        wr(O_CMP, 32'h0, 4'hF);
        wr(O_CNT, 32'hAAAA_AAAA, 4'hF);
        wr(O_CTRL, 32'h1, 4'hF);
        wr(O_CNT, 32'h1234_5678, 4'b0011);
        w = g_edge;
        rd(O_CNT);
        model(32'hAAAA_5678, 32'h0, 1'b0, g_edge - 1 - w, c, m);
        nchk++;
        if (g_rd !== c) begin
            nerr++;
            $display("FAIL count_write_tick got=%h want=%h", g_rd, c);
        end
        wr(O_CTRL, 32'h0, 4'hF);
    endtask

    task automatic test_clear_collision;
        int e;
        wr(O_CTRL, 32'h0, 4'hF);
        wr(O_STAT, 32'h1, 4'hF);
        wr(O_PRE, 32'h0, 4'hF);
        wr(O_CNT, 32'h0, 4'hF);
        wr(O_CMP, 32'd3, 4'hF);
        wr(O_CTRL, 32'h5, 4'hF);
        e = g_edge;
        while (cyc < e + 3) begin
            @(posedge clk); #1;
        end
        wr(O_STAT, 32'h1, 4'h1);
        rd(O_STAT);
        nchk++;
        if (g_rd !== 32'h1 || irq !== 1'b1) begin
            nerr++;
            $display("FAIL clear_collision got=%h irq=%b want=1 irq=1",
                     g_rd, irq);
        end
        wr(O_CTRL, 32'h0, 4'hF);
        wr(O_STAT, 32'h0, 4'hF);
        rd(O_STAT);
        nchk++;
        if (g_rd !== 32'h1) begin
            nerr++;
            $display("FAIL clear_write0 got=%h want=1", g_rd);
        end
        wr(O_STAT, 32'h1, 4'h1);
        rd(O_STAT);
        nchk++;
        if (g_rd !== 32'h0) begin
            nerr++;
            $display("FAIL clear_write1 got=%h want=0", g_rd);
        end
    endtask

    task automatic test_random;
        int e;
        int p;
        int n;
        logic [31:0] st;
        logic [31:0] cmp;
        logic [31:0] c;
        bit au;
        bit ie;
        bit m;
        for (int it = 0; it < 10; it++) begin
            p   = $urandom_range(0, 3);
            st  = $urandom;
            if (it % 3 == 0) st = 32'hFFFF_FFF8 + $urandom_range(0, 7);
            cmp = st + $urandom_range(0, 12);
            au  = 1'($urandom_range(0, 1));
            ie  = 1'($urandom_range(0, 1));
            wr(O_CTRL, 32'h0, 4'hF);
            wr(O_STAT, 32'h1, 4'hF);
            wr(O_PRE, 32'(p), 4'hF);
            wr(O_CNT, st, 4'hF);
            wr(O_CMP, cmp, 4'hF);
            wr(O_CTRL, {29'h0, ie, au, 1'b1}, 4'hF);
            e = g_edge;
            repeat ($urandom_range(0, 30)) @(posedge clk);
            #1;
            rd(O_CNT);
            n = (g_edge - 1 - e) / (p + 1);
            model(st, cmp, au, n, c, m);
            nchk++;
            if (g_rd !== c) begin
                nerr++;
                $display("FAIL rand_count it=%0d got=%h want=%h",
                         it, g_rd, c);
            end
            rd(O_STAT);
            n = (g_edge - 1 - e) / (p + 1);
            model(st, cmp, au, n, c, m);
            nchk++;
            if (g_rd !== {31'h0, m}) begin
                nerr++;
                $display("FAIL rand_match it=%0d got=%h want=%0d",
                         it, g_rd, m);
            end
            n = (cyc - e) / (p + 1);
            model(st, cmp, au, n, c, m);
            nchk++;
            if (irq !== (m & ie)) begin
                nerr++;
                $display("FAIL rand_irq it=%0d got=%b want=%b",
                         it, irq, m & ie);
            end
        end
        wr(O_CTRL, 32'h0, 4'hF);
    endtask

    task automatic test_reset_mid;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = O_CMP;
        bus.mem_wdata = 32'hDEAD_BEEF;
        bus.mem_wstrb = 4'hF;
        reset = 1'b1;
        @(posedge clk); #1;
        nchk++;
        if (bus.mem_ready !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mid_ack got=%b want=0", bus.mem_ready);
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        reset = 1'b0;
        rd(O_CMP);
        nchk++;
        if (g_rd !== 32'h0) begin
            nerr++;
            $display("FAIL reset_mid_cmp got=%h want=0", g_rd);
        end
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0200_0000;
        bus.mem_wstrb = 4'h0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            nchk++;
            if (bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'h0) begin
                nerr++;
                $display("FAIL nonwindow k=%0d ready=%b rdata=%h want 0",
                         k, bus.mem_ready, bus.mem_rdata);
            end
        end
        bus.mem_valid = 1'b0;
    endtask

    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset;
        test_regs;
        test_match_autoreload;
        test_wrap;
        test_count_write_on_tick;
        test_clear_collision;
        test_random;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
